// File: rtl/ethernet_frame_pkg.sv
// Shared Ethernet framing constants for session registration: message types,
// reject reasons, field byte offsets, response lengths and the controller state type.
package ethernet_frame_pkg;

  localparam int PACKET_PAYLOAD_BYTES = 112;

  localparam logic [15:0] MSG_SESSION_REG      = 16'h0001;
  localparam logic [15:0] MSG_SESSION_ACCEPTED = 16'h0002;
  localparam logic [15:0] MSG_SESSION_REJECTED = 16'h0003;

  localparam logic [7:0] RSN_BAD_SESSION = 8'h01;
  localparam logic [7:0] RSN_BAD_LENGTH  = 8'h02;
  localparam logic [7:0] RSN_DUPLICATE   = 8'h03;

  localparam int OFF_DST_MAC    = 0;
  localparam int OFF_SRC_MAC    = 6;
  localparam int OFF_ETHERTYPE  = 12;
  localparam int OFF_MSGTYPE    = 14;
  localparam int OFF_REQ_ID     = 16;
  localparam int OFF_SESSION_ID = 20;
  localparam int OFF_EXCH_CODE  = 21;
  localparam int HDR_BYTES      = 14;

  localparam int ACCEPT_MSG_BYTES = 20;
  localparam int REJECT_MSG_BYTES = 21;
  localparam int RESP_BUF_BYTES   = 21;

  typedef enum logic [1:0] {
    ST_RX,
    ST_DECIDE,
    ST_TX,
    ST_DROP
  } sess_state_t;

endpackage

// File: rtl/session_reg_ctrl_if.sv
// Byte-wide AXI-Stream pair for session registration: RX request stream (s_axis)
// and TX response stream (m_axis).
interface session_reg_ctrl_if;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/session_resp_ser.sv
// Response serialiser: loads up to 21 bytes (first byte in the MSBs) plus a length
// and shifts them out on a byte-wide AXI-Stream master, holding data while stalled.
module session_resp_ser
  import ethernet_frame_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [RESP_BUF_BYTES*8-1:0]   resp_bytes,
  input  logic [4:0]                    resp_len,
  input  logic                          m_axis_tready,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast
);
  localparam int TOP = RESP_BUF_BYTES*8;

  logic [TOP-1:0] shift_q;
  logic [4:0]     remain_q;
  logic           hs;

  assign hs = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q       <= '0;
      remain_q      <= '0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      shift_q       <= resp_bytes << 8;
      remain_q      <= resp_len - 5'd1;
      m_axis_tdata  <= resp_bytes[TOP-1 -: 8];
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= (resp_len == 5'd1);
    end else if (hs) begin
      if (m_axis_tlast) begin
        m_axis_tdata  <= 8'h00;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end else begin
        // next byte is already at the top of the shift register
        m_axis_tdata <= shift_q[TOP-1 -: 8];
        shift_q      <= shift_q << 8;
        remain_q     <= remain_q - 5'd1;
        m_axis_tlast <= (remain_q == 5'd1);
      end
    end
  end
endmodule

// File: rtl/session_reg_ctrl.sv
// Session registration controller: parses registration frames, keeps a session bitmap
// and answers with accept/reject. Build option SESSION_DUP_REJECT_EN rejects re-registration.
module session_reg_ctrl
  import ethernet_frame_pkg::*;
#(
  parameter int MAX_SESSION_ID  = 63,
  parameter int EXP_FRAME_BYTES = PACKET_PAYLOAD_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  session_reg_ctrl_if.slave  bus,
  output logic [63:0]        session_valid,
  output logic [15:0]        accept_cnt,
  output logic [15:0]        reject_cnt
);
  sess_state_t state;
  logic        s_rdy;
  logic [10:0] byte_cnt;
  logic [7:0]  hdr [HDR_BYTES];
  logic [7:0]  msg_hi;
  logic [31:0] req_id;
  logic [7:0]  sess_id;

  logic        beat, rx_beat, msg_bad, tx_done, frame_clr, load_resp;
  logic        dup, accept;
  logic [7:0]  reason;
  logic [RESP_BUF_BYTES*8-1:0] resp_bytes;
  logic [4:0]  resp_len;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  assign bus.s_axis_tready = s_rdy;
  assign beat      = bus.s_axis_tvalid && s_rdy;
  assign rx_beat   = (state == ST_RX) && beat;
  assign msg_bad   = (byte_cnt == 11'(OFF_MSGTYPE + 1)) &&
                     ({msg_hi, bus.s_axis_tdata} != MSG_SESSION_REG);
  assign tx_done   = (state == ST_TX) && bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast;
  assign frame_clr = (rx_beat && msg_bad && bus.s_axis_tlast) ||
                     ((state == ST_DROP) && beat && bus.s_axis_tlast) || tx_done;
  assign load_resp = (state == ST_DECIDE);

  always_comb begin
    dup = 1'b0;
`ifdef SESSION_DUP_REJECT_EN
    dup = session_valid[sess_id[5:0]];
`endif
    reason = 8'h00;
    if (byte_cnt != 11'(EXP_FRAME_BYTES))  reason = RSN_BAD_LENGTH;
    else if (int'(sess_id) > MAX_SESSION_ID) reason = RSN_BAD_SESSION;
    else if (dup)                            reason = RSN_DUPLICATE;
    accept = (reason == 8'h00);
    resp_bytes = {hdr[6], hdr[7], hdr[8], hdr[9], hdr[10], hdr[11],
                  hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5],
                  hdr[12], hdr[13],
                  accept ? MSG_SESSION_ACCEPTED : MSG_SESSION_REJECTED,
                  req_id, reason};
    resp_len = accept ? 5'(ACCEPT_MSG_BYTES) : 5'(REJECT_MSG_BYTES);
  end

  // Field capture: bytes beyond the end of a short frame stay zero
  always_ff @(posedge clk) begin
    if (rst || frame_clr) begin
      byte_cnt <= '0;
      for (int i = 0; i < HDR_BYTES; i++) hdr[i] <= 8'h00;
      msg_hi  <= 8'h00;
      req_id  <= '0;
      sess_id <= 8'h00;
    end else if (rx_beat) begin
      byte_cnt <= sat_inc11(byte_cnt);
      if (byte_cnt < 11'(HDR_BYTES)) hdr[byte_cnt[3:0]] <= bus.s_axis_tdata;
      case (byte_cnt)
        11'(OFF_MSGTYPE):    msg_hi        <= bus.s_axis_tdata;
        11'(OFF_REQ_ID):     req_id[31:24] <= bus.s_axis_tdata;
        11'(OFF_REQ_ID + 1): req_id[23:16] <= bus.s_axis_tdata;
        11'(OFF_REQ_ID + 2): req_id[15:8]  <= bus.s_axis_tdata;
        11'(OFF_REQ_ID + 3): req_id[7:0]   <= bus.s_axis_tdata;
        11'(OFF_SESSION_ID): sess_id       <= bus.s_axis_tdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RX;
      s_rdy         <= 1'b0;
      session_valid <= '0;
      accept_cnt    <= '0;
      reject_cnt    <= '0;
    end else begin
      case (state)
        ST_RX: begin
          s_rdy <= 1'b1;
          if (rx_beat) begin
            if (msg_bad) begin
              if (!bus.s_axis_tlast) state <= ST_DROP;
            end else if (bus.s_axis_tlast) begin
              state <= ST_DECIDE;
              s_rdy <= 1'b0;
            end
          end
        end
        ST_DROP: begin
          s_rdy <= 1'b1;
          if (beat && bus.s_axis_tlast) state <= ST_RX;
        end
        ST_DECIDE: begin
          if (accept) begin
            session_valid[sess_id[5:0]] <= 1'b1;
            accept_cnt <= sat_inc16(accept_cnt);
          end else begin
            reject_cnt <= sat_inc16(reject_cnt);
          end
          state <= ST_TX;
        end
        ST_TX: begin
          if (tx_done) begin
            state <= ST_RX;
            s_rdy <= 1'b1;
          end
        end
        default: state <= ST_RX;
      endcase
    end
  end

  session_resp_ser u_ser (
    .clk           (clk),
    .rst           (rst),
    .load          (load_resp),
    .resp_bytes    (resp_bytes),
    .resp_len      (resp_len),
    .m_axis_tready (bus.m_axis_tready),
    .m_axis_tdata  (bus.m_axis_tdata),
    .m_axis_tvalid (bus.m_axis_tvalid),
    .m_axis_tlast  (bus.m_axis_tlast)
  );
endmodule

// File: tb/tb_session_reg_ctrl.sv
// Bench for session_reg_ctrl: table of registration frames with hand-computed
// outcomes, plus stalled-response and reset-during-response sequences.
module tb_session_reg_ctrl;
`ifdef SESSION_DUP_REJECT_EN
  localparam int DUP = 1;
`else
  localparam int DUP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  session_reg_ctrl_if bus();
  logic [63:0] session_valid;
  logic [15:0] accept_cnt, reject_cnt;

  session_reg_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .session_valid (session_valid),
    .accept_cnt    (accept_cnt),
    .reject_cnt    (reject_cnt)
  );

  typedef struct {
    int          len;
    logic [15:0] msg;
    logic [31:0] req;
    logic [7:0]  sid;
    bit          resp;
    logic [7:0]  rsn;
    logic [63:0] vmap;
    logic [15:0] acc;
    logic [15:0] rej;
  } vec_t;

  vec_t       vt [12];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] rx_q [$];
  bit         got_last = 1'b0;
  bit         tr_mode = 1'b0;
  bit         m_rdy = 1'b1;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [7:0] frm [256];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Response sink: picks tready for the coming edge, records handshakes, checks hold-while-stalled
  always @(negedge clk) begin
    #1;
    if (!rst && prev_stall) begin
      chk("hold_tvalid", bus.m_axis_tvalid, 1);
      chk("hold_tdata", bus.m_axis_tdata, prev_data);
      chk("hold_tlast", bus.m_axis_tlast, prev_last);
    end
    m_rdy = tr_mode ? ~m_rdy : 1'b1;
    bus.m_axis_tready = m_rdy;
    if (!rst && bus.m_axis_tvalid && m_rdy) begin
      rx_q.push_back(bus.m_axis_tdata);
      if (bus.m_axis_tlast) got_last = 1'b1;
    end
    prev_stall = !rst && bus.m_axis_tvalid && !m_rdy;
    prev_data  = bus.m_axis_tdata;
    prev_last  = bus.m_axis_tlast;
  end

  task automatic send_frame(input int len, input logic [15:0] msg, input logic [31:0] req,
                            input logic [7:0] sid);
    bit ok;
    for (int i = 0; i < 256; i++) begin
      if (i < 6)        frm[i] = 8'h11 + 8'(i);
      else if (i < 12)  frm[i] = 8'h21 + 8'(i - 6);
      else if (i == 12) frm[i] = 8'h88;
      else if (i == 13) frm[i] = 8'hB5;
      else if (i == 14) frm[i] = msg[15:8];
      else if (i == 15) frm[i] = msg[7:0];
      else if (i < 20)  frm[i] = req[8*(19-i) +: 8];
      else if (i == 20) frm[i] = sid;
      else if (i == 21) frm[i] = 8'h5A;
      else              frm[i] = 8'(i) ^ 8'hA5;
    end
    for (int i = 0; i < len; i++) begin
      bus.s_axis_tdata  = frm[i];
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tlast  = (i == len - 1);
      ok = 1'b0;
      for (int w = 0; w < 50 && !ok; w++) begin
        ok = bus.s_axis_tready;
        @(negedge clk);
      end
      if (!ok) chk("s_beat_accept", 0, 1);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic check_resp(input int len, input logic [7:0] rsn);
    logic [7:0] e [$];
    for (int i = 6; i < 12; i++) e.push_back(i < len ? frm[i] : 8'h00);
    for (int i = 0; i < 6; i++)  e.push_back(i < len ? frm[i] : 8'h00);
    for (int i = 12; i < 14; i++) e.push_back(i < len ? frm[i] : 8'h00);
    e.push_back(8'h00);
    e.push_back(rsn == 8'h00 ? 8'h02 : 8'h03);
    for (int i = 16; i < 20; i++) e.push_back(i < len ? frm[i] : 8'h00);
    if (rsn != 8'h00) e.push_back(rsn);
    chk("resp_len", rx_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < rx_q.size()) chk($sformatf("resp_byte%0d", i), rx_q[i], e[i]);
  endtask

  task automatic run_frame(input int len, input logic [15:0] msg, input logic [31:0] req,
                           input logic [7:0] sid, input bit resp, input logic [7:0] rsn);
    bit done, viol;
    rx_q.delete();
    got_last = 1'b0;
    send_frame(len, msg, req, sid);
    chk("tvalid_after_last_beat", bus.m_axis_tvalid, 0);
    @(negedge clk);
    chk("tvalid_cycle_after_decide", bus.m_axis_tvalid, resp);
    if (resp) begin
      done = 1'b0;
      viol = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
        if (got_last) done = 1'b1;
        else begin
          if (bus.s_axis_tready !== 1'b0) viol = 1'b1;
          @(negedge clk);
        end
      end
      chk("resp_complete", done, 1);
      chk("s_tready_low_in_tx", viol, 0);
      if (done) chk("s_tready_after_tx", bus.s_axis_tready, 1);
      check_resp(len, rsn);
    end else begin
      repeat (20) @(negedge clk);
      chk("no_resp", rx_q.size(), 0);
      chk("s_tready_idle", bus.s_axis_tready, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.s_axis_tdata  = 8'h00;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b1;

    vt[0]  = '{112, 16'h0001, 32'hDEADBEEF, 8'd5,   1'b1, 8'h00, 64'h20, 16'd1, 16'd0};
    vt[1]  = '{112, 16'h0001, 32'h12345678, 8'd64,  1'b1, 8'h01, 64'h20, 16'd1, 16'd1};
    vt[2]  = '{100, 16'h0001, 32'h11112222, 8'd5,   1'b1, 8'h02, 64'h20, 16'd1, 16'd2};
    vt[3]  = '{112, 16'h0007, 32'h33334444, 8'd7,   1'b0, 8'h00, 64'h20, 16'd1, 16'd2};
    vt[4]  = '{112, 16'h0001, 32'hCAFEF00D, 8'd7,   1'b1, 8'h00, 64'hA0, 16'd2, 16'd2};
    vt[5]  = '{112, 16'h0001, 32'h0BADF00D, 8'd5,   1'b1, (DUP != 0) ? 8'h03 : 8'h00,
               64'hA0, 16'(3 - DUP), 16'(2 + DUP)};
    vt[6]  = '{10,  16'h0001, 32'h99990000, 8'd5,   1'b1, 8'h02, 64'hA0, 16'(3 - DUP), 16'(3 + DUP)};
    vt[7]  = '{17,  16'h0001, 32'h55556666, 8'd3,   1'b1, 8'h02, 64'hA0, 16'(3 - DUP), 16'(4 + DUP)};
    vt[8]  = '{16,  16'h0009, 32'h0,        8'd3,   1'b0, 8'h00, 64'hA0, 16'(3 - DUP), 16'(4 + DUP)};
    vt[9]  = '{112, 16'h0001, 32'h77778888, 8'd63,  1'b1, 8'h00, 64'h8000_0000_0000_00A0,
               16'(4 - DUP), 16'(4 + DUP)};
    vt[10] = '{113, 16'h0001, 32'hAAAA5555, 8'd2,   1'b1, 8'h02, 64'h8000_0000_0000_00A0,
               16'(4 - DUP), 16'(5 + DUP)};
    vt[11] = '{112, 16'h0001, 32'h0F0F0F0F, 8'd255, 1'b1, 8'h01, 64'h8000_0000_0000_00A0,
               16'(4 - DUP), 16'(6 + DUP)};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_session_valid", session_valid, 0);
    chk("rst_accept_cnt", accept_cnt, 0);
    chk("rst_reject_cnt", reject_cnt, 0);
    chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_m_tlast", bus.m_axis_tlast, 0);
    chk("rst_m_tdata", bus.m_axis_tdata, 0);
    chk("rst_s_tready", bus.s_axis_tready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_tready", bus.s_axis_tready, 1);

    for (int i = 0; i < 12; i++) begin
      run_frame(vt[i].len, vt[i].msg, vt[i].req, vt[i].sid, vt[i].resp, vt[i].rsn);
      chk($sformatf("v%0d_session_valid", i), session_valid, vt[i].vmap);
      chk($sformatf("v%0d_accept_cnt", i), accept_cnt, vt[i].acc);
      chk($sformatf("v%0d_reject_cnt", i), reject_cnt, vt[i].rej);
    end

    // Response drained with tready toggling every cycle
    tr_mode = 1'b1;
    run_frame(112, 16'h0001, 32'hA5A50001, 8'd9, 1'b1, 8'h00);
    tr_mode = 1'b0;
    chk("stall_session_valid", session_valid, 64'h8000_0000_0000_02A0);
    chk("stall_accept_cnt", accept_cnt, 16'(5 - DUP));

    // Reset while byte 10 of a response is on the bus
    rx_q.delete();
    got_last = 1'b0;
    send_frame(112, 16'h0001, 32'h01020304, 8'd11);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (rx_q.size() >= 10) found = 1'b1;
      else @(negedge clk);
    end
    chk("tx_byte10_reached", found, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_m_tvalid", bus.m_axis_tvalid, 0);
    chk("abort_m_tlast", bus.m_axis_tlast, 0);
    chk("abort_m_tdata", bus.m_axis_tdata, 0);
    chk("abort_session_valid", session_valid, 0);
    chk("abort_accept_cnt", accept_cnt, 0);
    chk("abort_reject_cnt", reject_cnt, 0);
    chk("abort_s_tready", bus.s_axis_tready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_s_tready_after", bus.s_axis_tready, 1);
    chk("abort_partial_bytes", rx_q.size(), 10);
    run_frame(112, 16'h0001, 32'h0BB01234, 8'd5, 1'b1, 8'h00);
    chk("after_abort_session_valid", session_valid, 64'h20);
    chk("after_abort_accept_cnt", accept_cnt, 1);
    chk("after_abort_reject_cnt", reject_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
